store_buffer: RTL and testbench
===============================

# store_buffer

Write-buffer stage between the MEM-stage pipeline register and the 8-bit data memory. Stores from the pipeline are queued and retired to memory in idle memory cycles, so a store never waits on a memory port. Loads have priority on the memory port. A load whose address matches a queued store gets the youngest matching data instead of stale memory data. Load latency stays one cycle, as the data memory's registered read port requires.

## Interface
- `DEPTH`, default 4: number of buffer entries; power of two, 2..16.
- `AW`, default 8: address width.
- `DW`, default 8: data width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cpu_memread` in 1: load request this cycle.
- `cpu_memwrite` in 1: store request this cycle.
- `cpu_addr` in AW: request address.
- `cpu_wdata` in DW: store data.
- `cpu_rdata` out DW: load result, valid the cycle after the load request.
- `stall` out 1: store not accepted this cycle; the pipeline must hold the request.
- `sb_empty` out 1: no valid entries; used by halt and fence logic.
- `mem_memread` out 1: to data memory `memread`.
- `mem_memwrite` out 1: to data memory `memwrite`.
- `mem_addr` out AW: to data memory `addr`.
- `mem_writedata` out DW: to data memory `writedata`.
- `mem_readdata` in DW: from data memory `readdata`.

## Operation
- **Storage:** circular FIFO of DEPTH entries, each holding {valid, addr, data}, with head/tail pointers and a count of 0..DEPTH. Pointers wrap modulo DEPTH.
- **Illegal request:** `cpu_memread` and `cpu_memwrite` both high. The store is honoured and the read is ignored.
- **Load cycle** (`cpu_memread`=1):
  - Memory port outputs: `mem_memread`=1, `mem_memwrite`=0, `mem_addr`=`cpu_addr`.
  - `cpu_addr` is compared against all valid entries. On any match, the youngest match (closest to tail) is selected.
  - Registered at the clock edge: ld_q=1, hit_q=match, fwd_q=selected data.
- **Store** (`cpu_memwrite`=1, count<DEPTH):
  - Write {addr, data} at tail, set valid, advance tail.
  - If no drain happens the same cycle, count increments.
- **Full:** with count==DEPTH and `cpu_memwrite`=1, `stall`=1 and nothing is enqueued.
  - This stall is conservative: it applies even if a drain frees an entry the same cycle.
- **Drain** (no load this cycle and count>0):
  - Memory port outputs: `mem_memwrite`=1, `mem_addr`/`mem_writedata` = head entry.
  - Clear the head entry's valid bit and advance head.
- **Enqueue and drain in the same cycle:** count is unchanged.
- **Idle port:** with no load and empty buffer, all `mem_*` outputs are 0.
- **Read data:**
  - `cpu_rdata` = ld_q ? (hit_q ? fwd_q : `mem_readdata`) : 0.
  - The buffer hides memory data older than its queued stores.
- **Flags:** `sb_empty` = (count==0). `stall` = `cpu_memwrite` & (count==DEPTH).
- **Reset:**
  - Clears all valid bits, head, tail, count, ld_q, hit_q and fwd_q.
  - Queued stores are discarded, including one being drained that cycle.
  - Values after reset: `cpu_rdata`=0, `sb_empty`=1, `stall`=0 while `cpu_memwrite`=0, `mem_*` outputs=0 with no load.

## Timing
- `stall`, `sb_empty` and `mem_*` are combinational from current state and the cpu inputs; no registered delay.
- Store acceptance takes effect at the edge.
- An entry enqueued at edge N can drain in cycle N+1 at the earliest.
- **Load:** request in cycle N, `cpu_rdata` valid throughout cycle N+1.
  - A forwarded hit reflects buffer contents at the end of cycle N.
  - Entries never drain during a load cycle, so the forwarded entry stays consistent.
- **Store-to-load:** a store accepted at edge N is visible to a load in cycle N+1 through forwarding.
- A continuous stream of loads starves the drain. The buffer fills and the next store stalls. There is no forced drain.

## Configuration
- **`STORE_BUFFER_COALESCE_EN` defined:**
  - A store whose address matches a valid entry overwrites the youngest matching entry's data in place. No new entry is allocated, count is unchanged, and `stall` is not raised even when full.
  - Exception: if the only matching entry is the head and it drains this same cycle, a new entry is allocated instead (normal full/stall rules apply).
- **Not defined:** every store allocates a new entry. No address compare is done on the store path.

## Test plan
- **Reset:** assert `reset` for 2 cycles -> `sb_empty`=1, `cpu_rdata`=0, `mem_memwrite`=0, `stall`=0.
- **Store then drain:** store 0x5A to 0x10, then idle -> next cycle `mem_memwrite`=1, `mem_addr`=0x10, `mem_writedata`=0x5A; one cycle later `sb_empty`=1.
- **Forwarding:** store 0x11 then 0x22 to address 0x20, load 0x20 back-to-back -> `cpu_rdata`=0x22 the cycle after the load, with memory still holding an older value.
- **Full and stall (macro off, DEPTH=4):** 4 stores interleaved with loads to 0x80 to block drains, then a 5th store -> `stall`=1 and the 5th store is not enqueued. After one idle cycle drains an entry, the store is accepted.
- **Coalescing (macro on, DEPTH=4):** fill with 4 stores to 0x01..0x04 under continuous loads, then store 0x99 to 0x03 -> `stall`=0, count stays 4, and the drain writes 0x99 to 0x03.
- **Reset mid-operation:** 3 stores queued, then `reset` -> `sb_empty`=1, and a subsequent load of those addresses returns `mem_readdata` (0x00).

Source files
------------

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Write buffer between the MEM-stage pipeline register and an 8-bit data
//   memory with a registered read port. Stores are queued in a circular FIFO
//   and retired to memory in cycles where no load owns the port. Loads
//   forward the youngest matching queued store, so queued data always hides
//   older memory contents. Load latency stays one cycle.
//
//   Optional feature: define STORE_BUFFER_COALESCE_EN to merge a store into
//   the youngest valid entry with the same address instead of allocating.
//
// Parameters
//   DEPTH : number of entries (power of two, 2..16)
//   AW    : address width
//   DW    : data width
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   cpu_memread      : load request this cycle
//   cpu_memwrite     : store request this cycle
//   cpu_addr         : request address
//   cpu_wdata        : store data
//   cpu_rdata        : load result, valid the cycle after the request
//   stall            : store not accepted this cycle (buffer full)
//   sb_empty         : no valid entries
//   mem_memread      : data memory read enable
//   mem_memwrite     : data memory write enable
//   mem_addr         : data memory address
//   mem_writedata    : data memory write data
//   mem_readdata     : data memory registered read data
//
// Handshake: a store is accepted at the rising edge of any cycle where
//   cpu_memwrite=1 and stall=0; while stall=1 the pipeline holds the request.
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_memread,
  input  logic          cpu_memwrite,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  output logic          sb_empty,
  output logic          mem_memread,
  output logic          mem_memwrite,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_writedata,
  input  logic [DW-1:0] mem_readdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          valid_q [DEPTH];
  logic          valid_d [DEPTH];
  logic [AW-1:0] addr_q  [DEPTH];
  logic [AW-1:0] addr_d  [DEPTH];
  logic [DW-1:0] data_q  [DEPTH];
  logic [DW-1:0] data_d  [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ld_q, ld_d;
  logic          hit_q, hit_d;
  logic [DW-1:0] fwd_q, fwd_d;

  logic          full;
  logic          ld_take;
  logic          drain;
  logic          alloc;
  logic          coalesce;
  logic          match_hit;
  logic [PW-1:0] match_sel;
  logic [PW-1:0] idx;

  // Youngest-match search: walk from head (oldest) to tail (youngest); a later
  // hit overrides an earlier one. Shared by load forwarding and coalescing.
  always_comb begin
    match_hit = 1'b0;
    match_sel = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && (addr_q[idx] == cpu_addr)) begin
        match_hit = 1'b1;
        match_sel = idx;
      end
    end
  end

  // cpu_memread owns the memory port whenever it is high, which also blocks
  // the drain. With both requests high the store wins and the read result is
  // discarded (ld_d=0), so cpu_rdata returns 0 the next cycle. Reset also
  // blocks the drain so a store being retired that cycle is truly dropped.
  assign full    = (count_q == CW'(DEPTH));
  assign ld_take = cpu_memread & ~cpu_memwrite;
  assign drain   = ~reset & ~cpu_memread & (count_q != '0);

`ifdef STORE_BUFFER_COALESCE_EN
  // If the youngest match is the head, it is the only match; when it leaves
  // this cycle the store must allocate instead.
  assign coalesce = cpu_memwrite & match_hit & ~(drain & (match_sel == head_q));
`else
  assign coalesce = 1'b0;
`endif

  assign stall    = cpu_memwrite & full & ~coalesce;
  assign alloc    = cpu_memwrite & ~full & ~coalesce;
  assign sb_empty = (count_q == '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      addr_d[i]  = addr_q[i];
      data_d[i]  = data_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(alloc) - CW'(drain);

    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    // alloc never targets the draining head: alloc needs count<DEPTH and
    // drain needs count>0, so tail != head whenever both happen.
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = cpu_addr;
      data_d[tail_q]  = cpu_wdata;
      tail_d          = tail_q + 1'b1;
    end
    if (coalesce) begin
      data_d[match_sel] = cpu_wdata;
    end

    ld_d  = ld_take;
    hit_d = ld_take & match_hit;
    fwd_d = (ld_take & match_hit) ? data_q[match_sel] : '0;
  end

  // Memory port: a load takes priority, otherwise the head entry drains.
  always_comb begin
    mem_memread   = 1'b0;
    mem_memwrite  = 1'b0;
    mem_addr      = '0;
    mem_writedata = '0;
    if (cpu_memread) begin
      mem_memread = 1'b1;
      mem_addr    = cpu_addr;
    end else if (drain) begin
      mem_memwrite  = 1'b1;
      mem_addr      = addr_q[head_q];
      mem_writedata = data_q[head_q];
    end
  end

  assign cpu_rdata = ld_q ? (hit_q ? fwd_q : mem_readdata) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ld_q    <= 1'b0;
      hit_q   <= 1'b0;
      fwd_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= valid_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ld_q    <= ld_d;
      hit_q   <= hit_d;
      fwd_q   <= fwd_d;
    end
  end

  // Payload storage needs no reset; it is only read through valid entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_q[i] <= addr_d[i];
      data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Directed bench for store_buffer (DEPTH=4, AW=8, DW=8) with a behavioural
//   data memory that has a registered read port. Inputs change on the falling
//   edge; outputs are sampled 1 ns later, well away from the rising edge.
//   With STORE_BUFFER_COALESCE_EN defined the full/stall section is replaced
//   by the coalescing section.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_memread;
  logic       cpu_memwrite;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       stall;
  logic       sb_empty;
  logic       mem_memread;
  logic       mem_memwrite;
  logic [7:0] mem_addr;
  logic [7:0] mem_writedata;
  logic [7:0] mem_readdata;

  logic       mem_init;
  logic [7:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(8), .DW(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_memread   (cpu_memread),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .stall         (stall),
    .sb_empty      (sb_empty),
    .mem_memread   (mem_memread),
    .mem_memwrite  (mem_memwrite),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata)
  );

  // ---------------- data memory model ----------------
  // 0x20 starts at 0x33 so forwarding can be told apart from memory data.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h20]   <= 8'h33;
      mem_readdata <= 8'h00;
    end else begin
      if (mem_memwrite) mem[mem_addr] <= mem_writedata;
      if (mem_memread)  mem_readdata  <= mem[mem_addr];
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    reset        = rst;
    cpu_memread  = rd;
    cpu_memwrite = wr;
    cpu_addr     = a;
    cpu_wdata    = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_drain(input string tag, input logic [7:0] a,
                             input logic [7:0] d);
    check_eq({tag, "_we"},   16'(mem_memwrite),  16'h1);
    check_eq({tag, "_addr"}, 16'(mem_addr),      16'(a));
    check_eq({tag, "_data"}, 16'(mem_writedata), 16'(d));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    cpu_addr = 8'h00; cpu_wdata = 8'h00; mem_init = 1'b1;

    // Reset held for two edges
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    mem_init = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle();
    check_eq("rst_empty", 16'(sb_empty),     16'h1);
    check_eq("rst_rdata", 16'(cpu_rdata),    16'h0);
    check_eq("rst_memwr", 16'(mem_memwrite), 16'h0);
    check_eq("rst_memrd", 16'(mem_memread),  16'h0);
    check_eq("rst_stall", 16'(stall),        16'h0);

    // Store then drain
    drive(1'b0, 1'b0, 1'b1, 8'h10, 8'h5A);
    check_eq("st_stall", 16'(stall),        16'h0);
    check_eq("st_memwr", 16'(mem_memwrite), 16'h0);
    check_eq("st_empty", 16'(sb_empty),     16'h1);
    idle();
    check_drain("drain1", 8'h10, 8'h5A);
    check_eq("drain1_empty", 16'(sb_empty), 16'h0);
    idle();
    check_eq("drained_empty", 16'(sb_empty),     16'h1);
    check_eq("drained_memwr", 16'(mem_memwrite), 16'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    check_eq("ld10_memrd", 16'(mem_memread), 16'h1);
    check_eq("ld10_addr",  16'(mem_addr),    16'h10);
    idle();
    check_eq("ld10_rdata", 16'(cpu_rdata), 16'h5A);

    // Forwarding: two stores to 0x20 held in the buffer, memory holds 0x33
    drive(1'b0, 1'b1, 1'b1, 8'h20, 8'h11);
    check_eq("fw_st1_stall", 16'(stall), 16'h0);
    drive(1'b0, 1'b1, 1'b1, 8'h20, 8'h22);
    check_eq("illegal_rd_ignored", 16'(cpu_rdata), 16'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
    check_eq("fw_ld_memwr", 16'(mem_memwrite), 16'h0);
    check_eq("fw_ld_memrd", 16'(mem_memread),  16'h1);
    idle();
    check_eq("fw_rdata_young", 16'(cpu_rdata), 16'h22);
    check_drain("fw_drain_old", 8'h20, 8'h11);
    drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h00);
    idle();
    check_eq("fw_rdata_hides_mem", 16'(cpu_rdata), 16'h22);
    check_drain("fw_drain_new", 8'h20, 8'h22);
    idle();
    check_eq("fw_empty", 16'(sb_empty), 16'h1);

`ifdef STORE_BUFFER_COALESCE_EN
    // Coalescing: fill under continuous reads, then overwrite 0x03 in place
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 1'b1, 8'(8'h01 + i), 8'(8'hD1 + i));
    drive(1'b0, 1'b1, 1'b1, 8'h03, 8'h99);
    check_eq("co_stall", 16'(stall), 16'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h03, 8'h00);
    idle();
    check_eq("co_fwd", 16'(cpu_rdata), 16'h99);
    check_drain("co_d1", 8'h01, 8'hD1);
    idle();
    check_drain("co_d2", 8'h02, 8'hD2);
    idle();
    check_drain("co_d3", 8'h03, 8'h99);
    idle();
    check_drain("co_d4", 8'h04, 8'hD4);
    idle();
    check_eq("co_empty", 16'(sb_empty), 16'h1);
`else
    // Full and stall: stores with the read line high keep the port busy
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 1'b1, 8'(8'h30 + i), 8'(8'hC0 + i));
    drive(1'b0, 1'b1, 1'b1, 8'h34, 8'hC4);
    check_eq("full_stall", 16'(stall),    16'h1);
    check_eq("full_empty", 16'(sb_empty), 16'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h32, 8'h00);
    check_eq("full_ld_nostall", 16'(stall), 16'h0);
    idle();
    check_eq("full_fwd", 16'(cpu_rdata), 16'hC2);
    check_drain("full_d0", 8'h30, 8'hC0);
    drive(1'b0, 1'b0, 1'b1, 8'h34, 8'hC4);
    check_eq("retry_stall", 16'(stall), 16'h0);
    check_drain("full_d1", 8'h31, 8'hC1);
    idle();
    check_drain("full_d2", 8'h32, 8'hC2);
    idle();
    check_drain("full_d3", 8'h33, 8'hC3);
    idle();
    check_drain("full_d4", 8'h34, 8'hC4);
    idle();
    check_eq("full_end_empty", 16'(sb_empty),     16'h1);
    check_eq("full_end_memwr", 16'(mem_memwrite), 16'h0);
`endif

    // Reset mid-operation discards queued stores
    drive(1'b0, 1'b1, 1'b1, 8'h40, 8'hE0);
    drive(1'b0, 1'b1, 1'b1, 8'h41, 8'hE1);
    drive(1'b0, 1'b1, 1'b1, 8'h42, 8'hE2);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("mid_rst_memwr", 16'(mem_memwrite), 16'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h40, 8'h00);
    check_eq("mid_rst_empty", 16'(sb_empty), 16'h1);
    drive(1'b0, 1'b1, 1'b0, 8'h41, 8'h00);
    check_eq("mid_rst_ld40", 16'(cpu_rdata), 16'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h42, 8'h00);
    check_eq("mid_rst_ld41", 16'(cpu_rdata), 16'h00);
    idle();
    check_eq("mid_rst_ld42", 16'(cpu_rdata), 16'h00);
    check_eq("mid_rst_memwr2", 16'(mem_memwrite), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
